id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised ID/EX pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a stall-cycle counter. It sits between the decode and execute stages. It replaces the free-running ID/EX latch so that the execute stage can back-pressure decode without a combinational ready path, and so that branch/exception logic can squash the in-flight instruction. Payload fields are width-configurable for ISA and datapath variants.

## Interface

Parameters:
- ALUOP_W, 8, ALU operation code width
- ALUSEL_W, 3, ALU result-select width
- DATA_W, 32, operand width
- RADDR_W, 5, destination register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  synchronous squash of all held entries
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage can accept this cycle
- id_aluop  in  ALUOP_W  ALU operation
- id_alusel  in  ALUSEL_W  result select
- id_reg1  in  DATA_W  operand 1
- id_reg2  in  DATA_W  operand 2
- id_wd  in  RADDR_W  destination register
- id_wreg  in  1  register write enable
- ex_valid  out  1  execute payload valid
- ex_ready  in  1  execute consumes this cycle
- ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg  out  (matching widths)  registered payload
- stall_cnt  out  CNT_W  count of cycles with ex_valid=1 and ex_ready=0

## Operation

- Storage: main register drives the ex_* outputs directly. Skid register holds one overflow entry.
- id_ready = ~skid_full, decoded from state flops only. There is no combinational path from ex_ready.
- Transfer in: id_valid & id_ready. Transfer out: ex_valid & ex_ready.
- States:
  - EMPTY: ex_valid=0, id_ready=1. On transfer in, load main and go to BUSY.
  - BUSY: ex_valid=1, id_ready=1.
    - In & out: main <= input, stay in BUSY.
    - In & ~ex_ready: skid <= input, go to FULL.
    - ~in & out: go to EMPTY.
    - Neither: hold.
  - FULL: ex_valid=1, id_ready=0.
    - On out: main <= skid, go to BUSY.
    - Otherwise hold.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- flush (highest priority, synchronous):
  - Next state is EMPTY and both entries are discarded.
  - Any input presented the same cycle is dropped, even if id_valid & id_ready.
  - ex_* payload clears to 0, so a bubble always carries ex_wreg=0.
- Invalid cycles: when ex_valid=0, ex_wreg must read 0. All other payload fields hold their last value, or 0 after reset/flush.
- stall_cnt:
  - Increments each cycle with ex_valid & ~ex_ready.
  - Saturates at 2^CNT_W-1.
  - Unaffected by flush; cleared only by reset.

## Timing

- Reset (rst=0, asynchronous) drives:
  - ex_valid=0
  - all ex_* payload = 0
  - stall_cnt=0
  - state EMPTY
  - id_ready=1 (reflects EMPTY state)
- Latency is 1 cycle from transfer in to ex_valid, in EMPTY or BUSY.
- Throughput is 1 instruction/cycle while ex_ready=1.
- When ex_ready drops, one further input is absorbed into the skid. id_ready falls the following cycle.
- In FULL, a transfer out raises id_ready the next cycle. The skid entry appears on ex_* in that same next cycle, with no bubble.
- Flush asserted in cycle N: ex_valid=0 and id_ready=1 from cycle N+1.
- Reset deassertion: first transfer is accepted on the first rising edge after rst returns to 1. Reset asserted mid-operation discards all entries immediately.

## Test plan

- Reset/idle: hold rst=0 with id_valid=1 and random payload. Require ex_valid=0, id_ready=1, all ex_*=0, stall_cnt=0. After release, the first id_valid with id_reg1=0x11111111 appears on ex_reg1 one cycle later.
- Streaming: 8 back-to-back instructions, id_wd=1..8, ex_ready=1. Require ex_wd=1..8 on consecutive cycles, with the first one cycle after the first input and no bubbles.
- Back-pressure/skid:
  - Stream id_wd=1,2,3 and drop ex_ready the cycle wd=1 is on the output.
  - Require id_ready=0 after wd=2 is skidded, and ex_wd to hold 1.
  - Re-raise ex_ready; require output order 1,2,3 with nothing lost.
  - Require stall_cnt to equal the number of held cycles.
- Flush in FULL: with both entries held, assert flush for one cycle alongside a new id_valid. Next cycle require ex_valid=0, ex_wreg=0, id_ready=1, and that none of the three entries ever appears.
- Counter saturation: CNT_W=4, ex_valid=1, ex_ready=0 for 20 cycles. Require stall_cnt=15 that stays 15, and that a flush leaves it at 15.
- Async reset mid-stream: drop rst between clock edges while in FULL. Require ex_valid=0 immediately, without waiting for a clk edge, and all state to be cleared.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake and a one-entry skid buffer.
//
// The main register drives the ex_* outputs directly. The skid register absorbs
// the one instruction that decode may still send in the cycle execute stalls.
// Because id_ready is decoded from state flops only, it never depends on ex_ready.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           synchronous squash of every held entry (highest priority)
//   id_valid/ready  decode-side handshake
//   id_*            decode payload (aluop, alusel, reg1, reg2, wd, wreg)
//   ex_valid/ready  execute-side handshake
//   ex_*            registered payload; ex_wreg reads 0 whenever ex_valid is 0
//   stall_cnt       saturating count of cycles with ex_valid=1 and ex_ready=0
module id_ex_stage #(
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [RADDR_W-1:0]  id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [RADDR_W-1:0]  ex_wd,
  output logic                ex_wreg,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned PayW = ALUOP_W + ALUSEL_W + 2 * DATA_W + RADDR_W + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e            state_q, state_d;
  logic [PayW-1:0]   main_q, main_d;
  logic [PayW-1:0]   skid_q, skid_d;
  logic [PayW-1:0]   in_pay;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              main_wreg;
  logic              xfer_in, xfer_out;

  assign in_pay = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, main_wreg} = main_q;

  assign ex_valid  = (state_q != StEmpty);
  assign id_ready  = (state_q != StFull);
  // A held-over payload must never look like a register write.
  assign ex_wreg   = main_wreg & ex_valid;
  assign stall_cnt = cnt_q;

  assign xfer_in  = id_valid & id_ready;
  assign xfer_out = ex_valid & ex_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (xfer_in) begin
            main_d  = in_pay;
            state_d = StBusy;
          end
        end
        StBusy: begin
          if (xfer_in && xfer_out) begin
            main_d = in_pay;
          end else if (xfer_in) begin
            skid_d  = in_pay;
            state_d = StFull;
          end else if (xfer_out) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (xfer_out) begin
            main_d  = skid_q;
            state_d = StBusy;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Stall counter ignores flush; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (ex_valid && !ex_ready && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed table, hand sequences for flush,
// saturation and async reset, then random traffic against a queue-based model.
module tb_id_ex_stage;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } pay_t;

  typedef struct {
    logic        v;
    logic        rdy;
    logic [4:0]  wd;
    logic        ev;
    logic        er;
    logic [4:0]  ewd;
    int unsigned estall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic id_valid = 1'b0;
  logic ex_ready = 1'b0;
  pay_t drv = '0;

  logic        id_ready, ex_valid, ex_wreg;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1, ex_reg2;
  logic [4:0]  ex_wd;
  logic [15:0] stall_cnt;

  logic        id_ready4, ex_valid4, ex_wreg4;
  logic [7:0]  ex_aluop4;
  logic [2:0]  ex_alusel4;
  logic [31:0] ex_reg14, ex_reg24;
  logic [4:0]  ex_wd4;
  logic [3:0]  stall_cnt4;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(drv.aluop), .id_alusel(drv.alusel), .id_reg1(drv.reg1), .id_reg2(drv.reg2),
    .id_wd(drv.wd), .id_wreg(drv.wreg), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready4),
    .id_aluop(drv.aluop), .id_alusel(drv.alusel), .id_reg1(drv.reg1), .id_reg2(drv.reg2),
    .id_wd(drv.wd), .id_wreg(drv.wreg), .ex_valid(ex_valid4), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop4), .ex_alusel(ex_alusel4), .ex_reg1(ex_reg14), .ex_reg2(ex_reg24),
    .ex_wd(ex_wd4), .ex_wreg(ex_wreg4), .stall_cnt(stall_cnt4)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: an ordered queue of at most two held instructions.
  pay_t        mq[$];
  pay_t        last_pay;
  int unsigned mcnt, mcnt4;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_pay = '0;
    mcnt     = 0;
    mcnt4    = 0;
  endtask

  task automatic check_model();
    pay_t act, exp;
    act = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg};
    if (mq.size() > 0) exp = mq[0];
    else begin
      exp      = last_pay;
      exp.wreg = 1'b0;
    end
    check("model ex_valid", ex_valid, mq.size() > 0);
    check("model id_ready", id_ready, mq.size() < 2);
    check("model payload", act, exp);
    check("model stall_cnt", stall_cnt, mcnt);
    check("model stall_cnt4", stall_cnt4, mcnt4);
  endtask

  task automatic model_edge();
    bit was_valid, pop, push;
    was_valid = mq.size() > 0;
    if (was_valid && !ex_ready) begin
      if (mcnt < 65535) mcnt++;
      if (mcnt4 < 15) mcnt4++;
    end
    if (flush) begin
      mq.delete();
      last_pay = '0;
    end else begin
      pop  = was_valid && ex_ready;
      push = id_valid && (mq.size() < 2);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(drv);
      if (mq.size() > 0) last_pay = mq[0];
    end
  endtask

  // Check pre-edge outputs, advance the model, cross the edge.
  task automatic step();
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pay(input logic [4:0] wd);
    drv.aluop  = 8'($urandom);
    drv.alusel = 3'($urandom);
    drv.reg1   = $urandom;
    drv.reg2   = $urandom;
    drv.wd     = wd;
    drv.wreg   = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t tbl[17];

  initial begin
    // Back-pressure rows 0..6, streaming rows 7..16.
    tbl[0] = '{1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 5'd0, 0};
    tbl[1] = '{1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 5'd1, 0};
    tbl[2] = '{1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 5'd1, 1};
    tbl[3] = '{1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 2};
    tbl[4] = '{1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd2, 2};
    tbl[5] = '{1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd3, 2};
    tbl[6] = '{1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 2};
    for (int i = 0; i < 8; i++) begin
      tbl[7+i] = '{1'b1, 1'b1, 5'(i + 1), (i != 0), 1'b1, 5'(i), 2};
    end
    tbl[15] = '{1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd8, 2};
    tbl[16] = '{1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 2};

    // Reset held with traffic presented.
    rst      = 1'b0;
    id_valid = 1'b1;
    ex_ready = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      rand_pay(5'($urandom));
      @(posedge clk);
      #1;
      check("reset ex_valid", ex_valid, 1'b0);
      check("reset id_ready", id_ready, 1'b1);
      check("reset payload", {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}, '0);
      check("reset stall_cnt", stall_cnt, '0);
    end
    @(negedge clk);
    rst = 1'b1;
    rand_pay(5'd9);
    drv.reg1 = 32'h1111_1111;
    step();
    check("first after reset ex_valid", ex_valid, 1'b1);
    check("first after reset ex_reg1", ex_reg1, 32'h1111_1111);
    id_valid = 1'b0;
    step();
    step();

    // Directed table.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      id_valid = tbl[i].v;
      ex_ready = tbl[i].rdy;
      rand_pay(tbl[i].wd);
      check($sformatf("tbl[%0d] ex_valid", i), ex_valid, tbl[i].ev);
      check($sformatf("tbl[%0d] id_ready", i), id_ready, tbl[i].er);
      if (tbl[i].ev) check($sformatf("tbl[%0d] ex_wd", i), ex_wd, tbl[i].ewd);
      check($sformatf("tbl[%0d] stall_cnt", i), stall_cnt, tbl[i].estall);
      step();
    end

    // Flush while FULL, with a new instruction offered the same cycle.
    id_valid = 1'b1; ex_ready = 1'b0; rand_pay(5'd10); step();
    rand_pay(5'd11); step();
    check("pre-flush id_ready", id_ready, 1'b0);
    flush = 1'b1; rand_pay(5'd12); step();
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    check("flush ex_valid", ex_valid, 1'b0);
    check("flush ex_wreg", ex_wreg, 1'b0);
    check("flush id_ready", id_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("flushed entry reappeared", ex_valid, 1'b0);
      step();
    end

    // Saturation of the 4-bit counter.
    id_valid = 1'b1; ex_ready = 1'b0; rand_pay(5'd5); step();
    id_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat stall_cnt4", stall_cnt4, 4'd15);
    step();
    check("sat stall_cnt4 holds", stall_cnt4, 4'd15);
    flush = 1'b1; step();
    flush = 1'b0;
    check("sat stall_cnt4 after flush", stall_cnt4, 4'd15);
    check("sat ex_valid after flush", ex_valid, 1'b0);
    step();

    // Async reset in FULL, between edges.
    id_valid = 1'b1; ex_ready = 1'b0; rand_pay(5'd20); step();
    rand_pay(5'd21); step();
    check("pre-reset id_ready", id_ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async reset ex_valid", ex_valid, 1'b0);
    check("async reset id_ready", id_ready, 1'b1);
    check("async reset payload", {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}, '0);
    check("async reset stall_cnt", stall_cnt, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    id_valid = 1'b0;
    step();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      flush    = ($urandom_range(15) == 0);
      id_valid = $urandom_range(1);
      ex_ready = ($urandom_range(3) != 0);
      rand_pay(5'($urandom));
      drv.wreg = $urandom_range(1);
      step();
    end
    flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
